// File: rtl/rand_seq_player.sv
// Captures a filtered pattern of random target indices from the LFSR and
// plays it back with timed show/gap phases, keeping it for replay and read-back.
module rand_seq_player #(
   parameter int SEQ_LEN     = 16,
   parameter int NUM_TARGETS = 9,
   parameter int DISP_CYCLES = 25000000,
   parameter int GAP_CYCLES  = 12500000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_random,
   input  logic       i_start,
   input  logic       i_replay,
   input  logic [4:0] i_level,
   input  logic [3:0] i_rd_addr,
   output logic [3:0] o_rd_data,
   output logic [3:0] o_mem_out,
   output logic       o_valid,
   output logic       o_busy,
   output logic       o_done,
   output logic [4:0] o_len
);

   localparam int TMAX = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] DISP_LAST = TW'(DISP_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
   localparam logic [4:0]    MAX_LEN   = 5'(SEQ_LEN);
   localparam logic [4:0]    N_TGT     = 5'(NUM_TARGETS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_SHOW,
      S_GAP,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [3:0]      r_mem [16];
   logic [4:0]      r_idx;
   logic [4:0]      r_tgt_len;
   logic [4:0]      r_len;
   logic [TW-1:0]   r_timer;
   logic [3:0]      r_mem_out;
   logic            r_valid;
   logic            r_done;

   state_t          w_state_nxt;
   logic [4:0]      w_idx_nxt;
   logic [4:0]      w_tgt_nxt;
   logic [4:0]      w_len_nxt;
   logic [TW-1:0]   w_timer_nxt;
   logic [3:0]      w_out_nxt;
   logic            w_valid_nxt;
   logic            w_done_nxt;
   logic            w_we;
   logic            w_accept;
   logic [3:0]      w_prev;
   logic [4:0]      w_clamped;

   assign w_prev    = r_mem[r_idx[3:0] - 4'd1];
   assign w_accept  = ({1'b0, i_random} < N_TGT) &&
                      ((r_idx == 5'd0) || (i_random != w_prev));
   assign w_clamped = (i_level == 5'd0)   ? 5'd1    :
                      (i_level > MAX_LEN) ? MAX_LEN : i_level;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_tgt_nxt   = r_tgt_len;
      w_len_nxt   = r_len;
      w_timer_nxt = r_timer;
      w_out_nxt   = r_mem_out;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_we        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_FILL;
               w_tgt_nxt   = w_clamped;
               w_idx_nxt   = 5'd0;
               w_len_nxt   = 5'd0;
            end else if (i_replay && (r_len != 5'd0)) begin
               w_state_nxt = S_SHOW;
               w_idx_nxt   = 5'd0;
               w_timer_nxt = '0;
               w_valid_nxt = 1'b1;
               w_out_nxt   = r_mem[0];
            end
         end
         S_FILL: begin
            if (w_accept) begin
               w_we = 1'b1;
               if (r_idx == r_tgt_len - 5'd1) begin
                  w_state_nxt = S_SHOW;
                  w_len_nxt   = r_tgt_len;
                  w_idx_nxt   = 5'd0;
                  w_timer_nxt = '0;
                  w_valid_nxt = 1'b1;
                  // a one-element pattern is being written on this very edge
                  w_out_nxt   = (r_idx == 5'd0) ? i_random : r_mem[0];
               end else begin
                  w_idx_nxt = r_idx + 5'd1;
               end
            end
         end
         S_SHOW: begin
            w_valid_nxt = 1'b1;
            if (r_timer == DISP_LAST) begin
               w_state_nxt = S_GAP;
               w_timer_nxt = '0;
               w_valid_nxt = 1'b0;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_GAP: begin
            if (r_timer == GAP_LAST) begin
               w_timer_nxt = '0;
               if (r_idx == r_len - 5'd1) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_SHOW;
                  w_idx_nxt   = r_idx + 5'd1;
                  w_valid_nxt = 1'b1;
                  w_out_nxt   = r_mem[r_idx[3:0] + 4'd1];
               end
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= 5'd0;
         r_tgt_len <= 5'd0;
         r_len     <= 5'd0;
         r_timer   <= '0;
         r_mem_out <= 4'd0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_tgt_len <= w_tgt_nxt;
         r_len     <= w_len_nxt;
         r_timer   <= w_timer_nxt;
         r_mem_out <= w_out_nxt;
         r_valid   <= w_valid_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 16; i++) r_mem[i] <= 4'd0;
      end else if (w_we) begin
         r_mem[r_idx[3:0]] <= i_random;
      end
   end

   assign o_rd_data = ({1'b0, i_rd_addr} < r_len) ? r_mem[i_rd_addr] : 4'd0;
   assign o_mem_out = r_mem_out;
   assign o_valid   = r_valid;
   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = r_done;
   assign o_len     = r_len;

endmodule

// File: tb/tb_rand_seq_player.sv
// Randomized bench for rand_seq_player against a queue-based pattern model
// and an arithmetic playback timeline (t / period, t % period).
module tb_rand_seq_player;

   localparam int DISP = 4;
   localparam int GAP  = 2;
   localparam int PER  = DISP + GAP;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] i_random = 4'd0;
   logic       i_start = 1'b0;
   logic       i_replay = 1'b0;
   logic [4:0] i_level = 5'd0;
   logic [3:0] i_rd_addr = 4'd0;
   logic [3:0] o_rd_data;
   logic [3:0] o_mem_out;
   logic       o_valid;
   logic       o_busy;
   logic       o_done;
   logic [4:0] o_len;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] pat[$];
   logic [3:0] stim[$];

   rand_seq_player #(
      .SEQ_LEN(16), .NUM_TARGETS(9), .DISP_CYCLES(DISP), .GAP_CYCLES(GAP)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_random(i_random),
      .i_start(i_start), .i_replay(i_replay), .i_level(i_level),
      .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
      .o_mem_out(o_mem_out), .o_valid(o_valid), .o_busy(o_busy),
      .o_done(o_done), .o_len(o_len)
   );

   always #5 clk = ~clk;

   function automatic int clamp(int lvl);
      if (lvl == 0) return 1;
      if (lvl > 16) return 16;
      return lvl;
   endfunction

   // pattern model: accept in-range values that differ from the previous one
   function automatic bit model_accept(logic [3:0] v, int len);
      if (pat.size() < len && v < 4'd9 && (pat.size() == 0 || v != pat[$]))
         pat.push_back(v);
      return pat.size() == len;
   endfunction

   // expected {busy, done, valid, mem_out} t cycles after SHOW entry
   function automatic logic [6:0] exp_vec(int t);
      int len = pat.size();
      int total = len * PER;
      if (t < total) return {1'b1, 1'b0, ((t % PER) < DISP), pat[t / PER]};
      if (t == total) return {1'b1, 1'b1, 1'b0, pat[len-1]};
      return {1'b0, 1'b0, 1'b0, pat[len-1]};
   endfunction

   // stimulus only: pulse start, feed values until the model says full
   task automatic do_fill(input int lvl);
      int len = clamp(lvl);
      bit fin = 1'b0;
      int k = 0;
      pat.delete();
      @(negedge clk);
      i_level = 5'(lvl);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      while (!fin && k < 400) begin
         logic [3:0] v;
         if (stim.size() > 0) v = stim.pop_front();
         else v = 4'($urandom_range(0, 15));
         i_random = v;
         fin = model_accept(v, len);
         k++;
         if (!fin) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({o_busy, o_done, o_valid, o_mem_out, o_len} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=0", {o_busy, o_done, o_valid, o_mem_out, o_len});
      end
      i_rd_addr = 4'd0;
      #1;
      n_checks++;
      if (o_rd_data !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_rd got=%0d exp=0", o_rd_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_busy got=%b exp=0", o_busy);
      end
   endtask

   task automatic test_filter();
      logic [3:0] seq [5] = '{4'd3, 4'd3, 4'd12, 4'd5, 4'd0};
      bit fin;
      pat.delete();
      @(negedge clk);
      i_level = 5'd3;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if ({o_busy, o_valid, o_len} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL fill_state i=%0d got=%b exp=%b", i, {o_busy, o_valid, o_len}, 7'b1000000);
         end
         i_random = seq[i];
         fin = model_accept(seq[i], 3);
      end
      for (int t = 0; t <= 3 * PER + 1; t++) begin
         @(negedge clk);
         n_checks++;
         if ({o_busy, o_done, o_valid, o_mem_out} !== exp_vec(t)) begin
            n_fail++;
            $display("FAIL filter_play t=%0d got=%b exp=%b", t, {o_busy, o_done, o_valid, o_mem_out}, exp_vec(t));
         end
         if (t == 0) begin
            n_checks++;
            if (o_len !== 5'd3) begin
               n_fail++;
               $display("FAIL filter_len got=%0d exp=3", o_len);
            end
         end
      end
      for (int a = 0; a < 4; a++) begin
         i_rd_addr = 4'(a);
         #1;
         n_checks++;
         if (o_rd_data !== ((a < 3) ? pat[a] : 4'd0)) begin
            n_fail++;
            $display("FAIL filter_rd a=%0d got=%0d exp=%0d", a, o_rd_data, (a < 3) ? pat[a] : 4'd0);
         end
      end
   endtask

   task automatic test_replay();
      @(negedge clk);
      i_random = 4'd7;
      i_replay = 1'b1;
      for (int t = 0; t <= 3 * PER + 1; t++) begin
         @(negedge clk);
         i_replay = 1'b0;
         n_checks++;
         if ({o_busy, o_done, o_valid, o_mem_out} !== exp_vec(t)) begin
            n_fail++;
            $display("FAIL replay_play t=%0d got=%b exp=%b", t, {o_busy, o_done, o_valid, o_mem_out}, exp_vec(t));
         end
      end
      n_checks++;
      if (o_len !== 5'd3) begin
         n_fail++;
         $display("FAIL replay_len got=%0d exp=3", o_len);
      end
   endtask

   task automatic test_clamp();
      do_fill(20);
      @(negedge clk);
      n_checks++;
      if (o_len !== 5'd16 || o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL clamp16 len=%0d valid=%b exp len=16 valid=1", o_len, o_valid);
      end
      repeat (16 * PER + 1) @(negedge clk);
      n_checks++;
      if ({o_busy, o_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL clamp16_end got=%b exp=00", {o_busy, o_done});
      end
      for (int a = 0; a < 16; a++) begin
         i_rd_addr = 4'(a);
         #1;
         n_checks++;
         if (o_rd_data !== pat[a]) begin
            n_fail++;
            $display("FAIL clamp16_rd a=%0d got=%0d exp=%0d", a, o_rd_data, pat[a]);
         end
      end
      do_fill(0);
      i_rd_addr = 4'd0;
      #1;
      n_checks++;
      if (o_len !== 5'd0 || o_rd_data !== 4'd0) begin
         n_fail++;
         $display("FAIL fill_clears_len len=%0d rd=%0d exp 0/0", o_len, o_rd_data);
      end
      for (int t = 0; t <= PER + 1; t++) begin
         @(negedge clk);
         n_checks++;
         if ({o_busy, o_done, o_valid, o_mem_out} !== exp_vec(t)) begin
            n_fail++;
            $display("FAIL clamp1_play t=%0d got=%b exp=%b", t, {o_busy, o_done, o_valid, o_mem_out}, exp_vec(t));
         end
      end
      i_rd_addr = 4'd0;
      #1;
      n_checks++;
      if (o_len !== 5'd1 || o_rd_data !== pat[0]) begin
         n_fail++;
         $display("FAIL clamp1 len=%0d rd0=%0d exp 1/%0d", o_len, o_rd_data, pat[0]);
      end
      i_rd_addr = 4'd5;
      #1;
      n_checks++;
      if (o_rd_data !== 4'd0) begin
         n_fail++;
         $display("FAIL clamp1_rd5 got=%0d exp=0", o_rd_data);
      end
   endtask

   task automatic test_ignored();
      do_fill(3);
      for (int t = 0; t <= 3 * PER + 1; t++) begin
         @(negedge clk);
         n_checks++;
         if ({o_busy, o_done, o_valid, o_mem_out} !== exp_vec(t)) begin
            n_fail++;
            $display("FAIL ignored_play t=%0d got=%b exp=%b", t, {o_busy, o_done, o_valid, o_mem_out}, exp_vec(t));
         end
         i_random = 4'($urandom_range(0, 15));
         i_start  = (t == 2);
         i_level  = 5'd7;
         i_replay = (t == 8);
      end
      i_start = 1'b0;
      i_replay = 1'b0;
      n_checks++;
      if (o_len !== 5'd3) begin
         n_fail++;
         $display("FAIL ignored_len got=%0d exp=3", o_len);
      end
      for (int a = 0; a < 3; a++) begin
         i_rd_addr = 4'(a);
         #1;
         n_checks++;
         if (o_rd_data !== pat[a]) begin
            n_fail++;
            $display("FAIL ignored_rd a=%0d got=%0d exp=%0d", a, o_rd_data, pat[a]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_fill(2);
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre valid=%b exp=1", o_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_busy, o_done, o_len, o_mem_out} !== 12'd0) begin
         n_fail++;
         $display("FAIL areset_now got=%b exp=0", {o_valid, o_busy, o_done, o_len, o_mem_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      pat.delete();
      @(negedge clk);
      i_replay = 1'b1;
      @(negedge clk);
      i_replay = 1'b0;
      n_checks++;
      if ({o_busy, o_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL areset_replay got=%b exp=00", {o_busy, o_valid});
      end
      do_fill(2);
      for (int t = 0; t <= 2 * PER + 1; t++) begin
         @(negedge clk);
         n_checks++;
         if ({o_busy, o_done, o_valid, o_mem_out} !== exp_vec(t)) begin
            n_fail++;
            $display("FAIL areset_play t=%0d got=%b exp=%b", t, {o_busy, o_done, o_valid, o_mem_out}, exp_vec(t));
         end
      end
      n_checks++;
      if (o_len !== 5'd2) begin
         n_fail++;
         $display("FAIL areset_len got=%0d exp=2", o_len);
      end
   endtask

   initial begin
      test_reset();
      test_filter();
      test_replay();
      test_clamp();
      test_ignored();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
